// File: rtl/raster_scan_ctrl_if.sv
// raster_scan_ctrl_if: bundles the draw-command, inside_test and framebuffer
// signals of raster_scan_ctrl. The controller connects through the slave
// modport; the surrounding system (command source, inside_test pipeline,
// framebuffer) uses the master modport.
interface raster_scan_ctrl_if #(
  parameter int unsigned ADDR_W = 20
);
  // draw command
  logic              start;
  logic [31:0]       x0;
  logic [31:0]       y0;
  logic [31:0]       x1;
  logic [31:0]       y1;
  logic [31:0]       x2;
  logic [31:0]       y2;
  logic              busy;
  logic              done;
  // inside_test request / response
  logic [31:0]       tri_x0;
  logic [31:0]       tri_y0;
  logic [31:0]       tri_x1;
  logic [31:0]       tri_y1;
  logic [31:0]       tri_x2;
  logic [31:0]       tri_y2;
  logic [31:0]       pixel_x;
  logic [31:0]       pixel_y;
  logic [31:0]       pixel_x_out;
  logic [31:0]       pixel_y_out;
  logic              is_inside;
  // framebuffer write port (no backpressure)
  logic              fb_we;
  logic [ADDR_W-1:0] fb_addr;
  logic [23:0]       fb_data;

  modport slave (
    input  start, x0, y0, x1, y1, x2, y2,
    input  pixel_x_out, pixel_y_out, is_inside,
    output busy, done,
    output tri_x0, tri_y0, tri_x1, tri_y1, tri_x2, tri_y2,
    output pixel_x, pixel_y,
    output fb_we, fb_addr, fb_data
  );

  modport master (
    output start, x0, y0, x1, y1, x2, y2,
    output pixel_x_out, pixel_y_out, is_inside,
    input  busy, done,
    input  tri_x0, tri_y0, tri_x1, tri_y1, tri_x2, tri_y2,
    input  pixel_x, pixel_y,
    input  fb_we, fb_addr, fb_data
  );
endinterface

// File: rtl/raster_scan_ctrl.sv
// raster_scan_ctrl: sequences one triangle through an external inside_test
// pipeline. On an accepted start the vertices are latched, a scan window is
// set up, one pixel per cycle is issued in raster order, validity is carried
// alongside the inside_test latency and every pixel reported inside produces
// a framebuffer write of COLOR.
//
// Build option TRI_BBOX_EN:
//   defined   - scan only the screen-clamped bounding box of the triangle
//               (an entirely off-screen box skips straight to the drain).
//   undefined - scan the whole screen 0..WIDTH-1 x 0..HEIGHT-1.
// The set of written addresses is the same in both builds.
module raster_scan_ctrl #(
  parameter int unsigned WIDTH   = 1280,
  parameter int unsigned HEIGHT  = 720,
  parameter int unsigned LATENCY = 3,
  parameter logic [23:0] COLOR   = 24'hFF00FF,
  parameter int unsigned ADDR_W  = 20
) (
  input  logic               pixel_clk,
  input  logic               rst,
  raster_scan_ctrl_if.slave  bus
);

  // last on-screen coordinates, used for clamping and emptiness tests
  localparam logic [31:0] X_LAST = 32'(WIDTH - 1);
  localparam logic [31:0] Y_LAST = 32'(HEIGHT - 1);

  // drain counter runs 0..LATENCY-1
  localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(LATENCY - 1);

  // FSM encoding
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_SCAN  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  // unsigned minimum of three coordinates
  function automatic logic [31:0] min3(input logic [31:0] a,
                                       input logic [31:0] b,
                                       input logic [31:0] c);
    logic [31:0] m;
    m = (a < b) ? a : b;
    return (m < c) ? m : c;
  endfunction

  // unsigned maximum of three coordinates
  function automatic logic [31:0] max3(input logic [31:0] a,
                                       input logic [31:0] b,
                                       input logic [31:0] c);
    logic [31:0] m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  logic [2:0]         state_q;
  logic [2:0]         state_d;

  logic [31:0]        tri_x0_q;
  logic [31:0]        tri_y0_q;
  logic [31:0]        tri_x1_q;
  logic [31:0]        tri_y1_q;
  logic [31:0]        tri_x2_q;
  logic [31:0]        tri_y2_q;

  logic [31:0]        xmin_q;
  logic [31:0]        xmax_q;
  logic [31:0]        ymax_q;

  logic [31:0]        px_q;
  logic [31:0]        py_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [LATENCY-1:0] valid_q;
  logic [LATENCY-1:0] valid_d;
  logic               busy_q;
  logic               done_q;

  logic [31:0]        bb_xmin_s;
  logic [31:0]        bb_xmax_s;
  logic [31:0]        bb_ymin_s;
  logic [31:0]        bb_ymax_s;
  logic               bb_empty_s;
  logic               accept_s;
  logic               issue_s;
  logic               row_end_s;
  logic               last_pix_s;
  logic [ADDR_W-1:0]  addr_s;

`ifdef TRI_BBOX_EN
  logic [31:0]        xmax_raw_s;
  logic [31:0]        ymax_raw_s;
`endif

  assign accept_s   = (state_q == S_IDLE) && bus.start;
  assign issue_s    = (state_q == S_SCAN);
  assign row_end_s  = (px_q == xmax_q);
  assign last_pix_s = row_end_s && (py_q == ymax_q);

  // scan window derived from the latched vertices (consumed in SETUP)
  always_comb begin
    bb_xmin_s  = 32'd0;
    bb_xmax_s  = X_LAST;
    bb_ymin_s  = 32'd0;
    bb_ymax_s  = Y_LAST;
    bb_empty_s = 1'b0;
`ifdef TRI_BBOX_EN
    xmax_raw_s = max3(tri_x0_q, tri_x1_q, tri_x2_q);
    ymax_raw_s = max3(tri_y0_q, tri_y1_q, tri_y2_q);
    bb_xmin_s  = min3(tri_x0_q, tri_x1_q, tri_x2_q);
    bb_ymin_s  = min3(tri_y0_q, tri_y1_q, tri_y2_q);
    if (xmax_raw_s > X_LAST) begin
      bb_xmax_s = X_LAST;
    end else begin
      bb_xmax_s = xmax_raw_s;
    end
    if (ymax_raw_s > Y_LAST) begin
      bb_ymax_s = Y_LAST;
    end else begin
      bb_ymax_s = ymax_raw_s;
    end
    bb_empty_s = (bb_xmin_s > X_LAST) || (bb_ymin_s > Y_LAST);
`endif
  end

  // next-state logic of the draw sequencer
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_SETUP;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SETUP: begin
        if (bb_empty_s) begin
          state_d = S_DRAIN;
        end else begin
          state_d = S_SCAN;
        end
      end
      S_SCAN: begin
        if (last_pix_s) begin
          state_d = S_DRAIN;
        end else begin
          state_d = S_SCAN;
        end
      end
      S_DRAIN: begin
        if (cnt_q == DRAIN_LAST) begin
          state_d = S_DONE;
        end else begin
          state_d = S_DRAIN;
        end
      end
      // start in the DONE cycle is deliberately not looked at
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // state register plus registered busy/done decoded from the next state
  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d == S_SETUP) || (state_d == S_SCAN) ||
                 (state_d == S_DRAIN);
      done_q  <= (state_d == S_DONE);
    end
  end

  // vertex capture on an accepted start; later input changes are ignored
  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      tri_x0_q <= 32'd0;
      tri_y0_q <= 32'd0;
      tri_x1_q <= 32'd0;
      tri_y1_q <= 32'd0;
      tri_x2_q <= 32'd0;
      tri_y2_q <= 32'd0;
    end else if (accept_s) begin
      tri_x0_q <= bus.x0;
      tri_y0_q <= bus.y0;
      tri_x1_q <= bus.x1;
      tri_y1_q <= bus.y1;
      tri_x2_q <= bus.x2;
      tri_y2_q <= bus.y2;
    end else begin
      tri_x0_q <= tri_x0_q;
      tri_y0_q <= tri_y0_q;
      tri_x1_q <= tri_x1_q;
      tri_y1_q <= tri_y1_q;
      tri_x2_q <= tri_x2_q;
      tri_y2_q <= tri_y2_q;
    end
  end

  // scan window registers, loaded once in SETUP
  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      xmin_q <= 32'd0;
      xmax_q <= 32'd0;
      ymax_q <= 32'd0;
    end else if (state_q == S_SETUP) begin
      xmin_q <= bb_xmin_s;
      xmax_q <= bb_xmax_s;
      ymax_q <= bb_ymax_s;
    end else begin
      xmin_q <= xmin_q;
      xmax_q <= xmax_q;
      ymax_q <= ymax_q;
    end
  end

  // raster-order pixel counters; they hold on the last pixel so that an
  // out-of-window coordinate is never presented to inside_test
  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      px_q <= 32'd0;
      py_q <= 32'd0;
    end else if ((state_q == S_SETUP) && !bb_empty_s) begin
      px_q <= bb_xmin_s;
      py_q <= bb_ymin_s;
    end else if (issue_s && !last_pix_s) begin
      if (row_end_s) begin
        px_q <= xmin_q;
        py_q <= py_q + 32'd1;
      end else begin
        px_q <= px_q + 32'd1;
        py_q <= py_q;
      end
    end else begin
      px_q <= px_q;
      py_q <= py_q;
    end
  end

  // counts the LATENCY drain cycles that let the last pixel retire
  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (state_q == S_DRAIN) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end else begin
      cnt_q <= '0;
    end
  end

  // next value of the validity pipe: stage 0 marks a pixel issued this cycle
  always_comb begin
    valid_d    = '0;
    valid_d[0] = issue_s;
    for (int i = 1; i < LATENCY; i++) begin
      valid_d[i] = valid_q[i-1];
    end
  end

  // validity pipe aligned with the inside_test latency
  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // framebuffer address, wrapped to ADDR_W bits
  always_comb begin
    addr_s = ADDR_W'(bus.pixel_y_out) * ADDR_W'(WIDTH) + ADDR_W'(bus.pixel_x_out);
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.tri_x0  = tri_x0_q;
  assign bus.tri_y0  = tri_y0_q;
  assign bus.tri_x1  = tri_x1_q;
  assign bus.tri_y1  = tri_y1_q;
  assign bus.tri_x2  = tri_x2_q;
  assign bus.tri_y2  = tri_y2_q;
  assign bus.pixel_x = px_q;
  assign bus.pixel_y = py_q;
  // the write strobe follows the returning result in the same cycle
  assign bus.fb_we   = valid_q[LATENCY-1] & bus.is_inside;
  assign bus.fb_addr = addr_s;
  assign bus.fb_data = COLOR;

endmodule

// File: tb/tb_raster_scan_ctrl.sv
// tb_raster_scan_ctrl: table-driven bench for raster_scan_ctrl on a 16x8
// screen with a 3-cycle inside_test. The bench also plays the inside_test
// pipeline (edge-function test, either winding) and the framebuffer.
module tb_raster_scan_ctrl;

  localparam int unsigned W   = 16;
  localparam int unsigned H   = 8;
  localparam int unsigned LAT = 3;
  localparam int unsigned AW  = 20;
  localparam logic [23:0] COL = 24'hFF00FF;

  typedef struct {
    logic [31:0] x0, y0, x1, y1, x2, y2;
    logic [31:0] xmin, ymin, xmax, ymax;
    logic        empty;
  } vec_t;

  logic pixel_clk = 1'b0;
  logic rst       = 1'b1;

  raster_scan_ctrl_if #(.ADDR_W(AW)) bus ();

  raster_scan_ctrl #(
    .WIDTH(W), .HEIGHT(H), .LATENCY(LAT), .COLOR(COL), .ADDR_W(AW)
  ) dut (
    .pixel_clk(pixel_clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 pixel_clk = ~pixel_clk;

  int   checks   = 0;
  int   failures = 0;
  vec_t tbl [7];
  vec_t cur;
  int   exp_q [$];
  int   wr_cnt, done_cnt, max_px, max_py;
  bit   sb_en, tri_bad;

  // inside test of the emulated inside_test block, accepting either winding
  function automatic bit inside_f(input logic [31:0] ax, ay, bx, by, cx, cy,
                                  input logic [31:0] qx, qy);
    longint l0, l1, l2;
    l0 = (longint'(bx) - longint'(ax)) * (longint'(qy) - longint'(ay)) -
         (longint'(by) - longint'(ay)) * (longint'(qx) - longint'(ax));
    l1 = (longint'(cx) - longint'(bx)) * (longint'(qy) - longint'(by)) -
         (longint'(cy) - longint'(by)) * (longint'(qx) - longint'(bx));
    l2 = (longint'(ax) - longint'(cx)) * (longint'(qy) - longint'(cy)) -
         (longint'(ay) - longint'(cy)) * (longint'(qx) - longint'(cx));
    return ((l0 <= 0) && (l1 <= 0) && (l2 <= 0)) ||
           ((l0 >= 0) && (l1 >= 0) && (l2 >= 0));
  endfunction

  // emulated inside_test pipeline of depth LAT
  logic [31:0] ex_q [LAT];
  logic [31:0] ey_q [LAT];
  logic        ein_q [LAT];
  always @(posedge pixel_clk) begin
    ex_q[0]  <= bus.pixel_x;
    ey_q[0]  <= bus.pixel_y;
    ein_q[0] <= inside_f(bus.tri_x0, bus.tri_y0, bus.tri_x1, bus.tri_y1,
                         bus.tri_x2, bus.tri_y2, bus.pixel_x, bus.pixel_y);
    for (int i = 1; i < LAT; i++) begin
      ex_q[i]  <= ex_q[i-1];
      ey_q[i]  <= ey_q[i-1];
      ein_q[i] <= ein_q[i-1];
    end
  end
  assign bus.pixel_x_out = ex_q[LAT-1];
  assign bus.pixel_y_out = ey_q[LAT-1];
  assign bus.is_inside   = ein_q[LAT-1];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic set_vtx(input vec_t v);
    bus.x0 = v.x0; bus.y0 = v.y0; bus.x1 = v.x1;
    bus.y1 = v.y1; bus.x2 = v.x2; bus.y2 = v.y2;
  endtask

  // advance to the next sampling point and run the framebuffer scoreboard
  task automatic tick();
    int e;
    @(negedge pixel_clk);
    if (sb_en) begin
      if (bus.busy) begin
        if (int'(bus.pixel_x) > max_px) max_px = int'(bus.pixel_x);
        if (int'(bus.pixel_y) > max_py) max_py = int'(bus.pixel_y);
        if (bus.tri_x0 != cur.x0 || bus.tri_y0 != cur.y0 || bus.tri_x1 != cur.x1 ||
            bus.tri_y1 != cur.y1 || bus.tri_x2 != cur.x2 || bus.tri_y2 != cur.y2)
          tri_bad = 1'b1;
      end
      if (bus.done) done_cnt++;
      if (bus.fb_we) begin
        wr_cnt++;
        if (exp_q.size() == 0) begin
          chk("fb_unexpected_write", 64'(bus.fb_addr), 64'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("fb_addr", 64'(bus.fb_addr), 64'(e));
        end
        chk("fb_data", 64'(bus.fb_data), 64'(COL));
      end
    end
  endtask

  // one draw: start is already high with the vertices on the bus (cycle 0)
  task automatic run_draw(input int idx, input bit hold);
    vec_t v;
    logic [31:0] ex0, ex1, ey0, ey1;
    bit emp;
    int n, cyc, exp_total;
    v = tbl[idx];
    cur = v;
`ifdef TRI_BBOX_EN
    ex0 = v.xmin; ex1 = v.xmax; ey0 = v.ymin; ey1 = v.ymax; emp = v.empty;
`else
    ex0 = 32'd0; ex1 = 32'(W - 1); ey0 = 32'd0; ey1 = 32'(H - 1); emp = 1'b0;
`endif
    n = emp ? 0 : int'((ex1 - ex0 + 32'd1) * (ey1 - ey0 + 32'd1));
    exp_q.delete();
    if (!emp) begin
      for (int y = int'(ey0); y <= int'(ey1); y++)
        for (int x = int'(ex0); x <= int'(ex1); x++)
          if (inside_f(v.x0, v.y0, v.x1, v.y1, v.x2, v.y2, 32'(x), 32'(y)))
            exp_q.push_back(y * W + x);
    end
    exp_total = exp_q.size();
    wr_cnt = 0; done_cnt = 0; max_px = 0; max_py = 0; tri_bad = 1'b0;

    tick();                                            // cycle 1
    chk($sformatf("busy_c1_v%0d", idx), 64'(bus.busy), 64'd1);
    if (!hold) bus.start = 1'b0;
    bus.x0 = $urandom; bus.y0 = $urandom; bus.x1 = $urandom; bus.y1 = $urandom;
    tick();                                            // cycle 2
    cyc = 2;
    if (!emp) begin
      chk($sformatf("first_px_v%0d", idx), 64'(bus.pixel_x), 64'(ex0));
      chk($sformatf("first_py_v%0d", idx), 64'(bus.pixel_y), 64'(ey0));
    end
    while (!bus.done && cyc < n + int'(LAT) + 40) begin
      bus.x2 = $urandom; bus.y2 = $urandom; bus.x0 = $urandom;
      tick();
      cyc++;
    end
    chk($sformatf("done_cycle_v%0d", idx), 64'(bus.done ? cyc : -1), 64'(n + 2 + int'(LAT)));
    if (!emp) begin
      chk($sformatf("last_px_v%0d", idx), 64'(bus.pixel_x), 64'(ex1));
      chk($sformatf("last_py_v%0d", idx), 64'(bus.pixel_y), 64'(ey1));
    end
    if (hold) set_vtx(v);
    tick();                                            // cycle after DONE
    chk($sformatf("busy_after_v%0d", idx), 64'(bus.busy), 64'd0);
    chk($sformatf("done_pulse_v%0d", idx), 64'(bus.done), 64'd0);
    chk($sformatf("wr_count_v%0d", idx), 64'(wr_cnt), 64'(exp_total));
    chk($sformatf("wr_left_v%0d", idx), 64'(exp_q.size()), 64'd0);
    chk($sformatf("done_count_v%0d", idx), 64'(done_cnt), 64'd1);
    chk($sformatf("tri_stable_v%0d", idx), 64'(tri_bad), 64'd0);
    chk($sformatf("px_bound_v%0d", idx), 64'(max_px > int'(W - 1)), 64'd0);
    chk($sformatf("py_bound_v%0d", idx), 64'(max_py > int'(H - 1)), 64'd0);
  endtask

  initial begin
    // vertices, then hand-computed clamped box and emptiness for a 16x8 screen
    tbl[0] = '{32'd5,  32'd1, 32'd1,  32'd6,  32'd10, 32'd5,  32'd1,  32'd1, 32'd10, 32'd6, 1'b0};
    tbl[1] = '{32'd20, 32'd1, 32'd25, 32'd2,  32'd22, 32'd3,  32'd20, 32'd1, 32'd15, 32'd3, 1'b1};
    tbl[2] = '{32'd12, 32'd6, 32'd30, 32'd6,  32'd12, 32'd20, 32'd12, 32'd6, 32'd15, 32'd7, 1'b0};
    tbl[3] = '{32'd0,  32'd0, 32'd4,  32'd4,  32'd8,  32'd8,  32'd0,  32'd0, 32'd8,  32'd7, 1'b0};
    tbl[4] = '{32'd3,  32'd3, 32'd3,  32'd3,  32'd3,  32'd3,  32'd3,  32'd3, 32'd3,  32'd3, 1'b0};
    tbl[5] = '{32'd0,  32'd0, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd5, 32'd0, 32'd0, 32'd15, 32'd5, 1'b0};
    tbl[6] = '{32'd1,  32'd9, 32'd2,  32'd10, 32'd3,  32'd11, 32'd1,  32'd9, 32'd3,  32'd7, 1'b1};

    sb_en = 1'b0;
    bus.start = 1'b0;
    set_vtx(tbl[0]);
    repeat (3) tick();
    chk("rst_busy",   64'(bus.busy),    64'd0);
    chk("rst_done",   64'(bus.done),    64'd0);
    chk("rst_fb_we",  64'(bus.fb_we),   64'd0);
    chk("rst_px",     64'(bus.pixel_x), 64'd0);
    chk("rst_py",     64'(bus.pixel_y), 64'd0);
    chk("rst_tri_x0", 64'(bus.tri_x0),  64'd0);
    chk("rst_tri_y2", 64'(bus.tri_y2),  64'd0);
    rst = 1'b0;
    tick();
    sb_en = 1'b1;

    for (int i = 0; i < 7; i++) begin
      set_vtx(tbl[i]);
      bus.start = 1'b1;
      run_draw(i, 1'b0);
    end

    // start held high through a draw and its DONE cycle, then accepted after
    set_vtx(tbl[0]);
    bus.start = 1'b1;
    run_draw(0, 1'b1);
    run_draw(0, 1'b0);

    // synchronous reset in the middle of a scan
    sb_en = 1'b0;
    set_vtx(tbl[0]);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (35) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_busy",   64'(bus.busy),    64'd0);
    chk("midrst_px",     64'(bus.pixel_x), 64'd0);
    chk("midrst_tri_x0", 64'(bus.tri_x0),  64'd0);
    for (int k = 0; k < int'(LAT); k++) begin
      chk($sformatf("midrst_fb_we_%0d", k), 64'(bus.fb_we), 64'd0);
      tick();
    end
    chk("midrst_idle_done", 64'(bus.done), 64'd0);
    sb_en = 1'b1;
    set_vtx(tbl[2]);
    bus.start = 1'b1;
    run_draw(2, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
